// File: rtl/sv_status_pkg.sv
// Shared status encoding and defaults for the job sequencer and its status flags.
package sv_status_pkg;

    localparam int LEN_W_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        BUSY  = 2'b01,
        DONE  = 2'b10,
        ERROR = 2'b11
    } status_t;

    function automatic logic [1:0] onehot2(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/sv_rr_arb2.sv
// Two-requester round-robin arbiter: on contention the requester that did not own last wins.
module sv_rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_owner,
    output logic       win
);

    always_comb begin
        win = 1'b0;
        case (req)
            2'b01:   win = 1'b0;
            2'b10:   win = 1'b1;
            2'b11:   win = ~last_owner;
            default: win = 1'b0;
        endcase
    end

endmodule

// File: rtl/sv_job_sequencer.sv
// Job sequencer: grants one of two requesters, runs a latched-length BUSY phase, then DONE or ERROR.
module sv_job_sequencer
    import sv_status_pkg::*;
#(
    parameter int LEN_W = LEN_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req,
    input  logic [LEN_W-1:0] len0,
    input  logic [LEN_W-1:0] len1,
    input  logic             fault,
    input  logic             clr_err,
    output logic [1:0]       state_out,
    output logic [1:0]       gnt,
    output logic             owner,
    output logic             done
);

    localparam logic [LEN_W-1:0] CNT_ONE = LEN_W'(1);

    status_t          state_q, state_d;
    logic [1:0]       gnt_q, gnt_d;
    logic             owner_q, owner_d;
    logic             done_q, done_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic             last_q, last_d;
    logic             win;
    logic [LEN_W-1:0] len_win;

    sv_rr_arb2 u_arb (
        .req        (req),
        .last_owner (last_q),
        .win        (win)
    );

    assign len_win = win ? len1 : len0;

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        owner_d = owner_q;
        done_d  = 1'b0;
        cnt_d   = cnt_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (req != 2'b00) begin
                    state_d = BUSY;
                    gnt_d   = onehot2(win);
                    owner_d = win;
                    // A zero length still runs one BUSY cycle.
                    cnt_d   = (len_win == '0) ? '0 : len_win - CNT_ONE;
                end
            end
            BUSY: begin
                if (fault) begin
                    state_d = ERROR;
                    gnt_d   = 2'b00;
                    last_d  = owner_q;
                end else if (cnt_q == '0) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            DONE: begin
                state_d = IDLE;
                gnt_d   = 2'b00;
                last_d  = owner_q;
            end
            ERROR: begin
                if (clr_err) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = 2'b00;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            gnt_q   <= 2'b00;
            owner_q <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            owner_q <= owner_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
        end
    end

    assign state_out = state_q;
    assign gnt       = gnt_q;
    assign owner     = owner_q;
    assign done      = done_q;

endmodule

// File: tb/tb_sv_job_sequencer.sv
// Directed bench for sv_job_sequencer: vector table plus hand-written multi-cycle sequences.
module tb_sv_job_sequencer;

    localparam logic [1:0] S_IDLE = 2'b00, S_BUSY = 2'b01, S_DONE = 2'b10, S_ERR = 2'b11;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] req;
    logic [7:0] len0, len1;
    logic       fault, clr_err;
    logic [1:0] state_out, gnt;
    logic       owner, done;

    int pass_cnt = 0;
    int tot_cnt  = 0;

    sv_job_sequencer #(.LEN_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .len0      (len0),
        .len1      (len1),
        .fault     (fault),
        .clr_err   (clr_err),
        .state_out (state_out),
        .gnt       (gnt),
        .owner     (owner),
        .done      (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [1:0] req;
        logic [7:0] len0;
        logic [7:0] len1;
        logic       fault;
        logic       clr;
        logic [1:0] st;
        logic [1:0] gnt;
        logic       own;
        logic       done;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic r, logic [1:0] rq, logic [7:0] l0, logic [7:0] l1,
                                logic f, logic c, logic [1:0] st, logic [1:0] g,
                                logic o, logic d);
        vec_t v;
        v.rst = r; v.req = rq; v.len0 = l0; v.len1 = l1; v.fault = f; v.clr = c;
        v.st = st; v.gnt = g; v.own = o; v.done = d;
        return v;
    endfunction

    task automatic step(logic r, logic [1:0] rq, logic [7:0] l0, logic [7:0] l1,
                        logic f, logic c);
        rst = r; req = rq; len0 = l0; len1 = l1; fault = f; clr_err = c;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string name, logic [1:0] st, logic [1:0] g, logic o, logic d);
        tot_cnt++;
        if (state_out === st && gnt === g && owner === o && done === d) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got state=%b gnt=%b owner=%b done=%b, expected state=%b gnt=%b owner=%b done=%b",
                     name, state_out, gnt, owner, done, st, g, o, d);
        end
    endtask

    initial begin
        int busy_n;
        int budget;

        rst = 1'b0; req = 2'b00; len0 = 8'd0; len1 = 8'd0; fault = 1'b0; clr_err = 1'b0;

        // Reset with aggressive inputs
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(0, 2'b11, 8'd4, 8'd4, 1, 0, S_IDLE, 2'b00, 0, 0));
        // Single job, len0=3, req dropped after grant
        vecs.push_back(mk(1, 2'b01, 8'd3, 8'd0, 0, 0, S_BUSY, 2'b01, 0, 0));
        vecs.push_back(mk(1, 2'b00, 8'd3, 8'd0, 0, 0, S_BUSY, 2'b01, 0, 0));
        vecs.push_back(mk(1, 2'b00, 8'd3, 8'd0, 0, 0, S_BUSY, 2'b01, 0, 0));
        vecs.push_back(mk(1, 2'b00, 8'd3, 8'd0, 0, 0, S_DONE, 2'b01, 0, 1));
        vecs.push_back(mk(1, 2'b00, 8'd3, 8'd0, 1, 1, S_IDLE, 2'b00, 0, 0));
        // Reset so the contention starts from last_owner=1
        vecs.push_back(mk(0, 2'b00, 8'd2, 8'd2, 0, 0, S_IDLE, 2'b00, 0, 0));
        for (int j = 0; j < 4; j++) begin
            logic       o;
            logic [1:0] g;
            o = j[0];
            g = o ? 2'b10 : 2'b01;
            vecs.push_back(mk(1, 2'b11, 8'd2, 8'd2, 0, 0, S_BUSY, g, o, 0));
            vecs.push_back(mk(1, 2'b11, 8'd2, 8'd2, 0, 0, S_BUSY, g, o, 0));
            vecs.push_back(mk(1, 2'b11, 8'd2, 8'd2, 0, 0, S_DONE, g, o, 1));
            vecs.push_back(mk(1, 2'b11, 8'd2, 8'd2, 1, 1, S_IDLE, 2'b00, o, 0));
        end

        foreach (vecs[k]) begin
            step(vecs[k].rst, vecs[k].req, vecs[k].len0, vecs[k].len1, vecs[k].fault, vecs[k].clr);
            chk($sformatf("vec%0d", k), vecs[k].st, vecs[k].gnt, vecs[k].own, vecs[k].done);
        end

        // Fault in the 4th BUSY cycle of a len0=10 job
        step(0, 2'b00, 8'd10, 8'd2, 0, 0);
        step(1, 2'b11, 8'd10, 8'd2, 0, 0);
        chk("fault_grant", S_BUSY, 2'b01, 0, 0);
        step(1, 2'b11, 8'd10, 8'd2, 0, 0);
        step(1, 2'b11, 8'd10, 8'd2, 0, 0);
        step(1, 2'b11, 8'd10, 8'd2, 0, 0);
        chk("fault_busy4", S_BUSY, 2'b01, 0, 0);
        step(1, 2'b11, 8'd10, 8'd2, 1, 0);
        chk("fault_enter", S_ERR, 2'b00, 0, 0);
        for (int i = 0; i < 5; i++) begin
            step(1, 2'b11, 8'd10, 8'd2, i[0], 0);
            chk($sformatf("fault_hold%0d", i), S_ERR, 2'b00, 0, 0);
        end
        step(1, 2'b11, 8'd10, 8'd2, 0, 1);
        chk("fault_clear", S_IDLE, 2'b00, 0, 0);
        step(1, 2'b11, 8'd10, 8'd2, 0, 0);
        chk("fault_next_rr", S_BUSY, 2'b10, 1, 0);

        // len1=0 runs exactly one BUSY cycle
        step(0, 2'b00, 8'd0, 8'd0, 0, 0);
        step(1, 2'b10, 8'd0, 8'd0, 0, 0);
        chk("len0_busy", S_BUSY, 2'b10, 1, 0);
        step(1, 2'b00, 8'd0, 8'd0, 0, 0);
        chk("len0_done", S_DONE, 2'b10, 1, 1);

        // len0=1 with fault in its only BUSY cycle: ERROR wins over completion
        step(0, 2'b00, 8'd1, 8'd0, 0, 0);
        step(1, 2'b01, 8'd1, 8'd0, 0, 0);
        chk("len1f_busy", S_BUSY, 2'b01, 0, 0);
        step(1, 2'b00, 8'd1, 8'd0, 1, 0);
        chk("len1f_err", S_ERR, 2'b00, 0, 0);
        step(1, 2'b00, 8'd1, 8'd0, 0, 0);
        chk("len1f_hold", S_ERR, 2'b00, 0, 0);

        // len0=255 with len0 changed after grant; must still run 255 BUSY cycles
        step(0, 2'b00, 8'd255, 8'd0, 0, 0);
        step(1, 2'b01, 8'd255, 8'd0, 0, 0);
        busy_n = 0;
        budget = 400;
        while (state_out == S_BUSY && budget > 0) begin
            busy_n++;
            budget--;
            step(1, 2'b00, 8'd3, 8'd0, 0, 0);
        end
        tot_cnt++;
        if (busy_n == 255) pass_cnt++;
        else $display("FAIL len255_count: got %0d BUSY cycles, expected 255", busy_n);
        chk("len255_done", S_DONE, 2'b01, 0, 1);

        // Reset on the 2nd BUSY cycle of a len0=5 job
        step(1, 2'b00, 8'd5, 8'd0, 0, 0);
        step(0, 2'b00, 8'd5, 8'd0, 0, 0);
        step(1, 2'b01, 8'd5, 8'd0, 0, 0);
        chk("midrst_busy1", S_BUSY, 2'b01, 0, 0);
        step(1, 2'b00, 8'd5, 8'd0, 0, 0);
        chk("midrst_busy2", S_BUSY, 2'b01, 0, 0);
        step(0, 2'b00, 8'd5, 8'd0, 0, 0);
        chk("midrst_abort", S_IDLE, 2'b00, 0, 0);
        step(1, 2'b11, 8'd5, 8'd5, 0, 0);
        chk("midrst_regrant", S_BUSY, 2'b01, 0, 0);

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule

// File: doc/sv_job_sequencer.md
SV_JOB_SEQUENCER -- requirements
Module: sv_job_sequencer

Interface
REQ-001 Parameter: LEN_W, default 8, job-length field width in bits.
REQ-002 Ports:
- clk, input, 1, single clock; all logic rising-edge.
- rst, input, 1, synchronous active-low reset.
- req, input, 2, per-requester job request level.
- len0, input, LEN_W, requester 0 job length in BUSY cycles.
- len1, input, LEN_W, requester 1 job length in BUSY cycles.
- fault, input, 1, datapath fault indication.
- clr_err, input, 1, clears ERROR.
- state_out, output, 2, status: 00 IDLE, 01 BUSY, 10 DONE, 11 ERROR.
- gnt, output, 2, one-hot ownership grant, high for the whole job.
- owner, output, 1, index of current or last job owner.
- done, output, 1, job-complete pulse.
REQ-003 The sequencer SHALL sample all inputs only on the rising edge of clk, and all outputs SHALL be registered.

Function
REQ-004 In IDLE with req!=00, the sequencer SHALL make the following updates at the next edge:
- state_out<=BUSY.
- gnt<=one-hot(winner).
- owner<=winner.
- cnt<=len_winner-1, with len 0 loading 0.
REQ-005 Arbitration SHALL be round-robin:
- Single request: that requester wins.
- req=11: the winner is the requester other than last_owner.
- last_owner resets to 1, so requester 0 wins the first contention.
REQ-006 A job SHALL hold BUSY for exactly max(len,1) cycles, with len latched at grant; later changes to len0 or len1 SHALL have no effect on a running job.
REQ-007 In BUSY, the sequencer SHALL evaluate in this priority order:
- fault=1: next state ERROR and gnt<=00.
- cnt==0: next state DONE.
- Otherwise: cnt decrements.
REQ-008 If fault and cnt==0 occur in the same cycle, ERROR SHALL win.
REQ-009 DONE SHALL last exactly one cycle with done=1, then return to IDLE with gnt<=00 and last_owner<=owner; done SHALL be 0 in every other state.
REQ-010 No grant SHALL be issued from DONE, so back-to-back jobs show one DONE cycle and one IDLE cycle between BUSY periods.
REQ-011 Deasserting req during BUSY SHALL NOT abort the job.
REQ-012 ERROR SHALL hold regardless of req until clr_err=1, then go to IDLE at the next edge; last_owner SHALL be updated to the faulted owner.
REQ-013 fault SHALL be ignored outside BUSY, and clr_err SHALL be ignored outside ERROR.
REQ-014 The counter SHALL be LEN_W bits and SHALL never wrap; it is not decremented at 0.

Reset
REQ-015 While rst=0 at an edge, the following SHALL be set regardless of other inputs:
- state_out=00.
- gnt=00, owner=0, done=0.
- cnt=0, last_owner=1.
REQ-016 Reset asserted mid-job (BUSY, DONE or ERROR) SHALL abort the job with no done pulse, and the first contention after reset SHALL grant requester 0.

Structure
REQ-017 Package sv_status_pkg SHALL hold the following shared items:
- typedef enum logic [1:0] status_t: IDLE=00, BUSY=01, DONE=10, ERROR=11.
- Default LEN_W constant.
The existing status-flag logic SHALL reuse the same encoding.
REQ-018 A combinational sub-module sv_rr_arb2 SHALL compute the winner from req and last_owner; the FSM, counter and pointer SHALL reside in sv_job_sequencer.

Verification
REQ-019 Reset: hold rst=0 for 3 cycles with req=11 and fault=1 -> state_out=00, gnt=00, done=0 and owner=0 throughout.
REQ-020 Single job: req=01 and len0=3 for one IDLE cycle -> gnt=01 and BUSY for exactly 3 cycles, then DONE with done=1 for 1 cycle, then IDLE with gnt=00.
REQ-021 Contention: req=11 held with len0=len1=2 -> grant sequence 01,10,01,10 and owner 0,1,0,1, with one DONE and one IDLE cycle between jobs.
REQ-022 Fault: len0=10 with fault=1 in the 4th BUSY cycle -> ERROR next cycle with gnt=00, held for 5 cycles with req=11; clr_err=1 -> IDLE, then gnt=10.
REQ-023 Boundaries, each checked separately:
- len1=0: BUSY for 1 cycle.
- len0=1 with fault in its only BUSY cycle: ERROR, done never 1.
- len0=255: 255 BUSY cycles with no wrap.
REQ-024 Reset mid-BUSY: rst=0 on the 2nd BUSY cycle of a len0=5 job -> IDLE at that edge with no done; then req=11 -> gnt=01.
